// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector built on an N-bit shift register.
// The pattern can be loaded at run time. Overlapping and non-overlapping
// detection are both supported. Each match gives a registered one-cycle pulse
// on z and bumps a saturating match counter.
module seq_detect_param #(
  parameter int              N               = 4,
  parameter logic [N-1:0]    DEFAULT_PATTERN = N'(4'b1011),
  parameter int              CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             count_clear,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic [N-1:0]     pattern
);

  localparam int              FILL_W  = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [N-1:0]      r_sr;
  logic [FILL_W-1:0] r_fill;
  logic [N-1:0]      r_pattern;
  logic              r_z;
  logic [CNT_W-1:0]  r_count;

  logic [N-1:0]      w_next_sr;
  logic [FILL_W-1:0] w_next_fill;
  logic              w_match;

  // Shift-register image after this edge's sample, plus the match decision.
  // NOTE: the fill guard is what stops a match before N fresh bits arrive.
  // It matters when the pattern is all zeros and sr has just been cleared.
  always_comb begin
    w_next_sr   = {r_sr[N-2:0], x};
    w_next_fill = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    w_match     = x_valid & ~pat_load & (r_fill >= FILL_ARM) &
                  (w_next_sr == r_pattern);
  end

  // Pattern, shift register, fill level and the registered match pulse.
  // NOTE: every assignment to state here is non-blocking, so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_fill    <= '0;
      r_pattern <= DEFAULT_PATTERN;
      r_z       <= 1'b0;
    end else if (pat_load) begin
      // A new pattern discards all history, including this edge's sample.
      r_pattern <= pat_in;
      r_sr      <= '0;
      r_fill    <= '0;
      r_z       <= 1'b0;
    end else begin
      r_z <= w_match;
      if (x_valid) begin
        if (w_match && !overlap) begin
          // Non-overlap mode: the next match must be built from fresh bits.
          r_sr   <= '0;
          r_fill <= '0;
        end else begin
          r_sr   <= w_next_sr;
          r_fill <= w_next_fill;
        end
      end
    end
  end

  // Saturating match counter. A clear on the same edge as a match still
  // counts that match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (count_clear) begin
      r_count <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign z           = r_z;
  assign match_count = r_count;
  assign pattern     = r_pattern;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param. One DUT uses the default 8-bit
// counter. A second DUT uses a 2-bit counter and shares the same inputs, so
// saturation can be seen.
module tb_seq_detect_param;

  logic       clk;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       count_clear;

  logic       z;
  logic [7:0] match_count;
  logic [3:0] pattern;
  logic       z_s;
  logic [1:0] match_count_s;
  logic [3:0] pattern_s;

  int errors = 0;
  int checks = 0;

  seq_detect_param #(.N(4), .DEFAULT_PATTERN(4'b1011), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clear(count_clear),
    .z(z), .match_count(match_count), .pattern(pattern)
  );

  seq_detect_param #(.N(4), .DEFAULT_PATTERN(4'b1011), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .count_clear(count_clear),
    .z(z_s), .match_count(match_count_s), .pattern(pattern_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs at the falling edge, then sample 1 ns after the
  // rising edge.
  task automatic step(input logic b, input logic v, input logic ld,
                      input logic [3:0] pin, input logic clr);
    @(negedge clk);
    x = b; x_valid = v; pat_load = ld; pat_in = pin; count_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(b, 1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; x = 1'b0; x_valid = 1'b0; pat_load = 1'b0; count_clear = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z got=%b exp=0", z); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", match_count); end
    checks++; if (pattern !== 4'b1011) begin errors++; $display("FAIL reset_pattern got=%b exp=1011", pattern); end
  endtask

  // Drive the 11-bit stream and compare z after every bit.
  task automatic run_stream(input string name, input logic [10:0] exp_z);
    logic [10:0] stream;
    stream = 11'b10110110010;
    for (int i = 0; i < 11; i++) begin
      bit_in(stream[10-i]);
      checks++;
      if (z !== exp_z[10-i]) begin
        errors++; $display("FAIL %s_z bit=%0d got=%b exp=%b", name, i, z, exp_z[10-i]);
      end
    end
  endtask

  task automatic test_overlap();
    do_reset();
    overlap = 1'b1;
    run_stream("ovl", 11'b00010010000);
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_count got=%0d exp=2", match_count); end
  endtask

  task automatic test_non_overlap();
    do_reset();
    overlap = 1'b0;
    run_stream("novl", 11'b00010000000);
    checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL novl_count got=%0d exp=1", match_count); end
  endtask

  task automatic test_load_stall();
    do_reset();
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    checks++; if (pattern !== 4'b0000) begin errors++; $display("FAIL ld_pattern got=%b exp=0000", pattern); end
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b0);
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL ld_early_z bit=%0d got=%b exp=0", i, z); end
    end
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL ld_stall_z got=%b exp=0", z); end
    bit_in(1'b0);
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL ld_fourth_z got=%b exp=1", z); end
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b0);
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL ld_run_z bit=%0d got=%b exp=1", i, z); end
    end
    checks++; if (match_count !== 8'd4) begin errors++; $display("FAIL ld_count got=%0d exp=4", match_count); end
  endtask

  task automatic test_load_race();
    logic [6:0] stream;
    logic [6:0] exp_z;
    do_reset();
    overlap = 1'b1;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    // This bit would complete 1011, but the load wins.
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL race_z got=%b exp=0", z); end
    checks++; if (pattern !== 4'b0110) begin errors++; $display("FAIL race_pattern got=%b exp=0110", pattern); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL race_count got=%0d exp=0", match_count); end
    // With fill back at 0, sr reads 0110 after three bits, but it must not
    // match until the fourth bit.
    stream = 7'b1100110;
    exp_z  = 7'b0000001;
    for (int i = 0; i < 7; i++) begin
      bit_in(stream[6-i]);
      checks++;
      if (z !== exp_z[6-i]) begin
        errors++; $display("FAIL race_fill_z bit=%0d got=%b exp=%b", i, z, exp_z[6-i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [0:8];
    exp_sat = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 9; i++) begin
      bit_in(1'b1);
      checks++;
      if (match_count_s !== exp_sat[i]) begin
        errors++; $display("FAIL sat_count bit=%0d got=%0d exp=%0d", i, match_count_s, exp_sat[i]);
      end
    end
    checks++; if (match_count !== 8'd6) begin errors++; $display("FAIL sat_wide_count got=%0d exp=6", match_count); end
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    checks++; if (match_count_s !== 2'd1) begin errors++; $display("FAIL clr_match_count got=%0d exp=1", match_count_s); end
    checks++; if (z_s !== 1'b1) begin errors++; $display("FAIL clr_match_z got=%b exp=1", z_s); end
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    checks++; if (match_count_s !== 2'd0) begin errors++; $display("FAIL clr_only_count got=%0d exp=0", match_count_s); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL clr_only_wide got=%0d exp=0", match_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    overlap = 1'b1;
    // Leave a non-default pattern in place so the reset has to restore it.
    step(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    @(negedge clk);
    reset = 1'b1; x = 1'b1; x_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL mid_rst_z got=%b exp=0", z); end
    @(negedge clk);
    reset = 1'b0;
    bit_in(1'b1);
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL mid_after_z got=%b exp=0", z); end
    checks++; if (pattern !== 4'b1011) begin errors++; $display("FAIL mid_pattern got=%b exp=1011", pattern); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", match_count); end
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; count_clear = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_load_stall();
    test_load_race();
    test_saturation();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
